// File: rtl/multicycle_ctrl.sv
// Multicycle controller for an ADDI/BNE subset.
// FETCH -> DECODE -> EXEC [-> WB] -> FETCH, with a sticky HALT.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        EQ,
  output logic        ir_load,
  output logic [11:0] imm_imm,
  output logic [11:0] imm_branch,
  output logic        ImmSrc,
  output logic        ALUsrc,
  output logic        RegWrite,
  output logic        pc_en,
  output logic        PCsrc,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_ADDI,
    C_BNE
  } cls_t;

  state_t      state;
  cls_t        cls;
  logic [31:0] ir;
  logic        dec_addi;
  logic        dec_bne;
  logic        unused;

  // Classify the incoming word so the decoded selects are
  // already registered when the FSM sits in DECODE.
  always_comb begin
    dec_addi = (instr[6:0] == 7'b0010011) &&
               (instr[14:12] == 3'b000);
    dec_bne  = (instr[6:0] == 7'b1100011) &&
               (instr[14:12] == 3'b001);
  end

  // Main FSM: IR capture, decoded class, sticky flag, retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      cls     <= C_NONE;
      ir      <= '0;
      ImmSrc  <= 1'b0;
      ALUsrc  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (instr_valid) begin
            ir     <= instr;
            ImmSrc <= dec_addi;
            ALUsrc <= dec_addi;
            if (dec_addi)
              cls <= C_ADDI;
            else if (dec_bne)
              cls <= C_BNE;
            else
              cls <= C_NONE;
            state  <= DECODE;
          end
        end
        DECODE: begin
          if (cls == C_NONE) begin
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cls == C_BNE) begin
            retired <= retired + 16'd1;
            state   <= FETCH;
          end else begin
            state <= WB;
          end
        end
        WB: begin
          retired <= retired + 16'd1;
          state   <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Pulses decode from state; rst masks any pending enable.
  assign ir_load  = ~rst & (state == FETCH) & instr_valid;
  assign RegWrite = ~rst & (state == WB);
  assign pc_en    = ~rst & ((state == WB) |
                    ((state == EXEC) & (cls == C_BNE)));
  assign PCsrc    = ~rst & (state == EXEC) &
                    (cls == C_BNE) & ~EQ;

  assign imm_imm    = ir[31:20];
  assign imm_branch = {ir[31], ir[7], ir[30:25], ir[11:8]};

  // Register-number fields are not needed by this controller.
  assign unused = ^{instr[19:15], ir[19:12], ir[6:0]};

endmodule
